rr_deserializer: RTL and testbench
==================================

// Module: rr_deserializer
//
// PURPOSE
//   Receive end of the round-robin lane multiplexer: takes one DATA_WIDTH word
//   per valid cycle, arriving in lane order 0..N_INPUTS-1, and rebuilds the
//   packed N_INPUTS-lane frame. The complete frame is presented on a
//   valid/ready output for downstream per-lane consumers.
//   Includes frame resync (in_sof), sticky overflow flag and sync-error pulse.
//
// PARAMETERS
//   DATA_WIDTH  16  width of one lane word
//   N_INPUTS    4   lanes per frame (>=1); CW = max(1,$clog2(N_INPUTS))
//
// PORTS
//   clk        in   1                    clock, all logic on posedge
//   rst        in   1                    synchronous, active-high reset
//   in_data    in   DATA_WIDTH           serial lane word
//   in_valid   in   1                    in_data valid this cycle; always accepted (no in_ready)
//   in_sof     in   1                    with in_valid: this word is lane 0 (resync)
//   out_data   out  DATA_WIDTH*N_INPUTS  frame; lane i at [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
//   out_valid  out  1                    out_data holds an undelivered frame
//   out_ready  in   1                    consumer takes frame when out_valid & out_ready
//   lane_mask  out  N_INPUTS             lanes already captured in the frame being built
//   overflow   out  1                    sticky: completed frame dropped; cleared only by rst
//   sync_err   out  1                    1-cycle pulse: in_sof arrived with lane counter != 0
//
// BEHAVIOUR
//   Reset (rst=1 at posedge): ctr=0, lane_mask=0, out_valid=0, out_data=0,
//     overflow=0, sync_err=0. Partial frame discarded. Inputs ignored that cycle.
//   Accept: each cycle with in_valid=1, in_data is written to shadow lane L.
//     L = 0 if in_sof=1, else L = ctr.
//     Then ctr <= (L==N_INPUTS-1) ? 0 : L+1, and lane_mask[L] <= 1.
//   Resync: in_valid & in_sof & ctr!=0 -> sync_err=1 next cycle. lane_mask is
//     cleared, then bit 0 is set. Old partial lanes are discarded.
//     in_sof with in_valid=0 is ignored.
//   Frame complete: a word is accepted at L=N_INPUTS-1.
//     - Output slot free (out_valid=0, or out_valid & out_ready this cycle):
//       next cycle out_data = shadow with lane N-1 = in_data, and out_valid=1.
//       Latency: 1 cycle after the last word.
//     - Output slot busy: frame dropped, overflow <= 1. out_data and out_valid
//       are unchanged.
//     - In both cases lane_mask <= 0 and ctr <= 0.
//   Output: while out_valid & !out_ready, out_data is stable.
//     Handshake with no new completion -> out_valid=0 next cycle.
//     Handshake and completion in the same cycle -> out_valid stays 1 and the
//     new frame is loaded (back-to-back, no bubble).
//   N_INPUTS=1: every accepted word completes a frame. lane_mask is always
//     0 after update; sync_err never fires.
//   Gaps (in_valid=0) mid-frame are legal: ctr and the shadow hold.
//
// STRUCTURE
//   Shared include (rr_defs.vh): CW width function/macro and the lane-slice
//     macro LANE(i,DW). The same definitions serve the scheduler side.
//   Top: lane counter, shadow registers, lane_mask, sync_err, overflow.
//   One sub-module frame_out_reg: a DATA_WIDTH*N_INPUTS valid/ready holding
//     register with a load strobe and a busy indication (out_valid & !out_ready).
//
// TESTING (DATA_WIDTH=16, N_INPUTS=4 unless noted)
//   1 Basic: rst, then words A0,A1,A2,A3 on 4 consecutive cycles, in_sof on A0,
//     out_ready=1 -> one cycle after A3: out_valid=1, out_data=A3A2A1A0
//     (lane0=16'hA0), lane_mask=0.
//   2 Back-to-back: 3 frames streamed with no gaps, out_ready=1 -> out_valid
//     high for a single cycle after each 4th word. All 12 words land in the
//     correct lanes.
//   3 Backpressure: out_ready=0, send 2 full frames -> frame 1 held stable,
//     frame 2 dropped, overflow=1 and stays 1. Raise out_ready -> frame 1
//     delivered, out_valid=0.
//   4 Resync: send B0,B1 then C0 with in_sof, then C1..C3 -> sync_err pulses
//     1 cycle after C0. The only output frame is C3C2C1C0.
//   5 Gaps and reset: D0,idle,D1,idle,D2,D3 -> frame D3..D0. Then E0,E1, rst,
//     F0..F3 -> only frame F emitted; all outputs 0 during reset.
//   6 N_INPUTS=1: words 5,6,7 with out_ready=1 -> out_data 5,6,7 on
//     consecutive cycles, 1-cycle latency.

Source files
------------

// File: rtl/rr_deserializer_pkg.sv
// Shared sizing helpers for the round-robin lane serializer/deserializer pair.
package rr_deserializer_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_N_INPUTS   = 4;

  // Lane counter width; a single-lane link still keeps a 1-bit counter.
  function automatic int cw_f(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Low bit of lane `lane` inside a packed frame of `dw`-bit lanes.
  function automatic int lane_lo(input int lane, input int dw);
    return lane * dw;
  endfunction

endpackage

// File: rtl/rr_deserializer_frame_out_reg.sv
// Valid/ready holding register for one rebuilt frame; busy means a frame is
// waiting and will not leave this cycle.
module frame_out_reg #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  output logic         busy_o
);

  logic [W-1:0] data_q;
  logic         valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (load_i) begin
        data_q  <= data_i;
        valid_q <= 1'b1;
      end else if (ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign busy_o  = valid_q & ~ready_i;

endmodule

// File: rtl/rr_deserializer.sv
// Rebuilds N_INPUTS-lane frames from a word-per-cycle lane stream, with
// in_sof resync, sticky overflow and a sync-error pulse.
module rr_deserializer
  import rr_deserializer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N_INPUTS   = DEF_N_INPUTS
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_WIDTH-1:0]          in_data,
  input  logic                           in_valid,
  input  logic                           in_sof,
  output logic [DATA_WIDTH*N_INPUTS-1:0] out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [N_INPUTS-1:0]            lane_mask,
  output logic                           overflow,
  output logic                           sync_err
);

  localparam int            CW        = cw_f(N_INPUTS);
  localparam int            FW        = DATA_WIDTH * N_INPUTS;
  localparam logic [CW-1:0] LAST_LANE = CW'(N_INPUTS - 1);

  logic [CW-1:0]       ctr_q, ctr_d;
  logic [CW-1:0]       lane;
  logic [N_INPUTS-1:0] lane_mask_q, lane_mask_d;
  logic [N_INPUTS-1:0] lane_hit;
  logic                sync_err_q;
  logic                overflow_q;
  logic                last_word;
  logic                busy;
  logic                load;
  logic [FW-1:0]       frame;

  assign lane      = in_sof ? '0 : ctr_q;
  assign last_word = in_valid && (lane == LAST_LANE);
  assign load      = last_word && !busy;

  // The final lane bypasses the shadow so a frame is presented one cycle
  // after its last word.
  genvar gi;
  generate
    for (gi = 0; gi < N_INPUTS; gi++) begin : g_lane
      assign lane_hit[gi] = (lane == CW'(gi));
      if (gi == N_INPUTS - 1) begin : g_bypass
        assign frame[lane_lo(gi, DATA_WIDTH) +: DATA_WIDTH] = in_data;
      end else begin : g_shadow
        logic [DATA_WIDTH-1:0] shadow_q;
        always_ff @(posedge clk) begin
          if (rst) begin
            shadow_q <= '0;
          end else if (in_valid && lane_hit[gi]) begin
            shadow_q <= in_data;
          end
        end
        assign frame[lane_lo(gi, DATA_WIDTH) +: DATA_WIDTH] = shadow_q;
      end
    end
  endgenerate

  always_comb begin
    ctr_d       = ctr_q;
    lane_mask_d = lane_mask_q;
    if (in_valid) begin
      if (last_word) begin
        ctr_d       = '0;
        lane_mask_d = '0;
      end else begin
        ctr_d       = lane + 1'b1;
        lane_mask_d = (in_sof ? '0 : lane_mask_q) | lane_hit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctr_q       <= '0;
      lane_mask_q <= '0;
      sync_err_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      ctr_q       <= ctr_d;
      lane_mask_q <= lane_mask_d;
      sync_err_q  <= in_valid && in_sof && (ctr_q != '0);
      if (last_word && busy) begin
        overflow_q <= 1'b1;
      end
    end
  end

  frame_out_reg #(
    .W(FW)
  ) u_out (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .data_i (frame),
    .ready_i(out_ready),
    .data_o (out_data),
    .valid_o(out_valid),
    .busy_o (busy)
  );

  assign lane_mask = lane_mask_q;
  assign overflow  = overflow_q;
  assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_rr_deserializer.sv
// Directed vector bench for rr_deserializer (4-lane table plus a 1-lane sequence).
module tb_rr_deserializer;

  typedef struct {
    logic        rst;
    logic        v;
    logic        sof;
    logic [15:0] d;
    logic        rdy;
    logic        ev;
    logic [63:0] ed;
    logic [3:0]  mask;
    logic        ovf;
    logic        serr;
  } vec_t;

  vec_t vecs[$];
  int   n_total = 0;
  int   n_pass  = 0;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_sof, out_ready;
  logic [15:0] in_data;
  logic [63:0] out_data;
  logic        out_valid, overflow, sync_err;
  logic [3:0]  lane_mask;

  logic        rst1, in_valid1, in_sof1, out_ready1;
  logic [15:0] in_data1;
  logic [15:0] out_data1;
  logic        out_valid1, overflow1, sync_err1;
  logic [0:0]  lane_mask1;

  always #5 clk = ~clk;

  rr_deserializer #(.DATA_WIDTH(16), .N_INPUTS(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .lane_mask(lane_mask), .overflow(overflow), .sync_err(sync_err)
  );

  rr_deserializer #(.DATA_WIDTH(16), .N_INPUTS(1)) dut1 (
    .clk(clk), .rst(rst1), .in_data(in_data1), .in_valid(in_valid1), .in_sof(in_sof1),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
    .lane_mask(lane_mask1), .overflow(overflow1), .sync_err(sync_err1)
  );

  function automatic logic [63:0] fr(input logic [15:0] b);
    return {b + 16'd3, b + 16'd2, b + 16'd1, b};
  endfunction

  task automatic add(input logic r, input logic v, input logic s, input logic [15:0] d,
                     input logic rdy, input logic ev, input logic [63:0] ed,
                     input logic [3:0] m, input logic o, input logic se);
    vec_t x;
    x.rst = r; x.v = v; x.sof = s; x.d = d; x.rdy = rdy;
    x.ev = ev; x.ed = ed; x.mask = m; x.ovf = o; x.serr = se;
    vecs.push_back(x);
  endtask

  task automatic chk(input string name, input int step, input logic [63:0] got,
                     input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s step %0d: got %h expected %h", name, step, got, exp);
  endtask

  initial begin
    logic [63:0] fa, f1, f2, f3, f4, f6, f7, f9, fd, ff;
    fa = fr(16'h00A0); f1 = fr(16'h0010); f2 = fr(16'h0020); f3 = fr(16'h0030);
    f4 = fr(16'h0040); f6 = fr(16'h0060); f7 = fr(16'h0070); f9 = fr(16'h0090);
    fd = fr(16'h00D0); ff = fr(16'h00F0);

    //   rst v sof data  rdy  ev  out_data mask ovf serr
    // basic frame
    add(1, 0, 0, 16'h0,  1,   0, 64'h0, 4'h0, 0, 0);
    add(0, 1, 1, 16'hA0, 1,   0, 64'h0, 4'h1, 0, 0);
    add(0, 1, 0, 16'hA1, 1,   0, 64'h0, 4'h3, 0, 0);
    add(0, 1, 0, 16'hA2, 1,   0, 64'h0, 4'h7, 0, 0);
    add(0, 1, 0, 16'hA3, 1,   1, fa,    4'h0, 0, 0);
    add(0, 0, 0, 16'h0,  1,   0, fa,    4'h0, 0, 0);
    // three frames streamed back to back
    add(0, 1, 1, 16'h10, 1,   0, fa,    4'h1, 0, 0);
    add(0, 1, 0, 16'h11, 1,   0, fa,    4'h3, 0, 0);
    add(0, 1, 0, 16'h12, 1,   0, fa,    4'h7, 0, 0);
    add(0, 1, 0, 16'h13, 1,   1, f1,    4'h0, 0, 0);
    add(0, 1, 1, 16'h20, 1,   0, f1,    4'h1, 0, 0);
    add(0, 1, 0, 16'h21, 1,   0, f1,    4'h3, 0, 0);
    add(0, 1, 0, 16'h22, 1,   0, f1,    4'h7, 0, 0);
    add(0, 1, 0, 16'h23, 1,   1, f2,    4'h0, 0, 0);
    add(0, 1, 0, 16'h30, 1,   0, f2,    4'h1, 0, 0);
    add(0, 1, 0, 16'h31, 1,   0, f2,    4'h3, 0, 0);
    add(0, 1, 0, 16'h32, 1,   0, f2,    4'h7, 0, 0);
    add(0, 1, 0, 16'h33, 1,   1, f3,    4'h0, 0, 0);
    add(0, 0, 0, 16'h0,  1,   0, f3,    4'h0, 0, 0);
    // backpressure: second frame dropped, first held
    add(0, 1, 1, 16'h40, 0,   0, f3,    4'h1, 0, 0);
    add(0, 1, 0, 16'h41, 0,   0, f3,    4'h3, 0, 0);
    add(0, 1, 0, 16'h42, 0,   0, f3,    4'h7, 0, 0);
    add(0, 1, 0, 16'h43, 0,   1, f4,    4'h0, 0, 0);
    add(0, 1, 1, 16'h50, 0,   1, f4,    4'h1, 0, 0);
    add(0, 1, 0, 16'h51, 0,   1, f4,    4'h3, 0, 0);
    add(0, 1, 0, 16'h52, 0,   1, f4,    4'h7, 0, 0);
    add(0, 1, 0, 16'h53, 0,   1, f4,    4'h0, 1, 0);
    add(0, 0, 0, 16'h0,  0,   1, f4,    4'h0, 1, 0);
    add(0, 0, 0, 16'h0,  1,   0, f4,    4'h0, 1, 0);
    // handshake and completion on the same edge
    add(0, 1, 1, 16'h60, 0,   0, f4,    4'h1, 1, 0);
    add(0, 1, 0, 16'h61, 0,   0, f4,    4'h3, 1, 0);
    add(0, 1, 0, 16'h62, 0,   0, f4,    4'h7, 1, 0);
    add(0, 1, 0, 16'h63, 0,   1, f6,    4'h0, 1, 0);
    add(0, 1, 1, 16'h70, 0,   1, f6,    4'h1, 1, 0);
    add(0, 1, 0, 16'h71, 0,   1, f6,    4'h3, 1, 0);
    add(0, 1, 0, 16'h72, 0,   1, f6,    4'h7, 1, 0);
    add(0, 1, 0, 16'h73, 1,   1, f7,    4'h0, 1, 0);
    add(0, 0, 0, 16'h0,  1,   0, f7,    4'h0, 1, 0);
    // resync mid-frame
    add(0, 1, 1, 16'h80, 1,   0, f7,    4'h1, 1, 0);
    add(0, 1, 0, 16'h81, 1,   0, f7,    4'h3, 1, 0);
    add(0, 1, 1, 16'h90, 1,   0, f7,    4'h1, 1, 1);
    add(0, 1, 0, 16'h91, 1,   0, f7,    4'h3, 1, 0);
    add(0, 1, 0, 16'h92, 1,   0, f7,    4'h7, 1, 0);
    add(0, 1, 0, 16'h93, 1,   1, f9,    4'h0, 1, 0);
    add(0, 0, 0, 16'h0,  1,   0, f9,    4'h0, 1, 0);
    // gaps, sof without valid ignored
    add(0, 1, 1, 16'hD0, 1,   0, f9,    4'h1, 1, 0);
    add(0, 0, 0, 16'h0,  1,   0, f9,    4'h1, 1, 0);
    add(0, 1, 0, 16'hD1, 1,   0, f9,    4'h3, 1, 0);
    add(0, 0, 1, 16'hEE, 1,   0, f9,    4'h3, 1, 0);
    add(0, 1, 0, 16'hD2, 1,   0, f9,    4'h7, 1, 0);
    add(0, 1, 0, 16'hD3, 1,   1, fd,    4'h0, 1, 0);
    // partial frame then reset (input during reset ignored)
    add(0, 1, 1, 16'hE0, 1,   0, fd,    4'h1, 1, 0);
    add(0, 1, 0, 16'hE1, 1,   0, fd,    4'h3, 1, 0);
    add(1, 1, 0, 16'hE2, 1,   0, 64'h0, 4'h0, 0, 0);
    add(0, 1, 1, 16'hF0, 1,   0, 64'h0, 4'h1, 0, 0);
    add(0, 1, 0, 16'hF1, 1,   0, 64'h0, 4'h3, 0, 0);
    add(0, 1, 0, 16'hF2, 1,   0, 64'h0, 4'h7, 0, 0);
    add(0, 1, 0, 16'hF3, 1,   1, ff,    4'h0, 0, 0);
    add(0, 0, 0, 16'h0,  1,   0, ff,    4'h0, 0, 0);

    rst1 = 1'b1; in_valid1 = 1'b0; in_sof1 = 1'b0; in_data1 = '0; out_ready1 = 1'b1;

    foreach (vecs[i]) begin
      rst = vecs[i].rst; in_valid = vecs[i].v; in_sof = vecs[i].sof;
      in_data = vecs[i].d; out_ready = vecs[i].rdy;
      @(posedge clk);
      #1;
      chk("out_valid", i, 64'(out_valid), 64'(vecs[i].ev));
      chk("out_data",  i, out_data,       vecs[i].ed);
      chk("lane_mask", i, 64'(lane_mask), 64'(vecs[i].mask));
      chk("overflow",  i, 64'(overflow),  64'(vecs[i].ovf));
      chk("sync_err",  i, 64'(sync_err),  64'(vecs[i].serr));
    end
    in_valid = 1'b0; in_sof = 1'b0;

    // single-lane instance: every word is a frame, 1-cycle latency
    rst1 = 1'b1;
    @(posedge clk); #1;
    chk("n1_reset_valid", 0, 64'(out_valid1), 64'(0));
    chk("n1_reset_data",  0, 64'(out_data1),  64'(0));
    rst1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid1 = 1'b1; in_sof1 = (k != 1); in_data1 = 16'(5 + k);
      @(posedge clk); #1;
      chk("n1_valid", k + 1, 64'(out_valid1), 64'(1));
      chk("n1_data",  k + 1, 64'(out_data1),  64'(5 + k));
      chk("n1_mask",  k + 1, 64'(lane_mask1), 64'(0));
      chk("n1_serr",  k + 1, 64'(sync_err1),  64'(0));
    end
    in_valid1 = 1'b0; in_sof1 = 1'b0;
    @(posedge clk); #1;
    chk("n1_idle_valid", 4, 64'(out_valid1), 64'(0));
    chk("n1_idle_data",  4, 64'(out_data1),  64'(7));
    chk("n1_overflow",   4, 64'(overflow1),  64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
